// File: rtl/mmio_uart_pkg.sv
// Shared constants and types for the MMIO UART bridge: register offsets,
// STATUS bit positions and the TX FSM state encoding.
package mmio_uart_pkg;

  localparam logic [3:0] OFF_TXDATA  = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_BAUDDIV = 4'h8;

  localparam int ST_BUSY_BIT   = 0;
  localparam int ST_FULL_BIT   = 1;
  localparam int ST_EMPTY_BIT  = 2;
  localparam int ST_OVF_BIT    = 3;
  localparam int ST_PARITY_BIT = 4;
  localparam int ST_COUNT_LSB  = 8;
  localparam int ST_COUNT_MSB  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
`ifdef MMIO_UART_PARITY_EN
    , ST_PARITY
`endif
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; push/pop requests are ignored
// when full/empty respectively.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/mmio_uart_bridge.sv
// Zero-wait-state data bus bridge splitting accesses between RAM and a
// transmit-only MMIO UART. Define MMIO_UART_PARITY_EN for 8E1 framing.
module mmio_uart_bridge
  import mmio_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 8,
  parameter int          BAUD_DIV_RST = 16,
  parameter logic [31:0] MMIO_BASE    = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_address,
  input  logic [31:0] write_data,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [31:0] read_data,
  input  logic [31:0] ram_read_data,
  output logic        ram_write,
  output logic        ram_read,
  output logic        uart_tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          mmio_hit;
  logic [3:0]    reg_off;
  logic          wr_txdata;
  logic          wr_status;
  logic          wr_bauddiv;

  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  logic          overflow;
  logic [15:0]   baud_div;
  logic [31:0]   status;

  tx_state_t     tx_state;
  logic [15:0]   div_lat;
  logic [15:0]   bit_timer;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic          bit_done;

  logic          unused_bits;
  assign unused_bits = ^{data_address[1:0], write_data[31:16]};

  assign mmio_hit  = (data_address[31:4] == MMIO_BASE[31:4]);
  assign reg_off   = {data_address[3:2], 2'b00};
  assign ram_write = mem_write & ~mmio_hit;
  assign ram_read  = mem_read & ~mmio_hit;

  assign wr_txdata  = mem_write & mmio_hit & (reg_off == OFF_TXDATA);
  assign wr_status  = mem_write & mmio_hit & (reg_off == OFF_STATUS);
  assign wr_bauddiv = mem_write & mmio_hit & (reg_off == OFF_BAUDDIV);

  // Fullness is judged on the pre-pop count, so a push into a full FIFO is
  // dropped even if the FSM pops at the same edge.
  assign fifo_push = wr_txdata & ~fifo_full;
  assign bit_done  = (bit_timer == 16'd0);
  assign fifo_pop  = ~fifo_empty &
                     ((tx_state == ST_IDLE) || ((tx_state == ST_STOP) && bit_done));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (write_data[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      baud_div <= 16'(BAUD_DIV_RST);
    end else begin
      if (wr_txdata && fifo_full)            overflow <= 1'b1;
      else if (wr_status && write_data[3])   overflow <= 1'b0;
      if (wr_bauddiv) baud_div <= (write_data[15:0] == 16'd0) ? 16'd1 : write_data[15:0];
    end
  end

  // Each state lasts div_lat cycles; the divisor is latched once per frame so
  // a BAUDDIV write mid-frame only affects the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= ST_IDLE;
      div_lat   <= 16'd1;
      bit_timer <= 16'd0;
      shreg     <= 8'd0;
      bit_idx   <= 3'd0;
      uart_tx   <= 1'b1;
    end else begin
      case (tx_state)
        ST_IDLE: begin
          uart_tx <= 1'b1;
          if (!fifo_empty) begin
            tx_state  <= ST_START;
            shreg     <= fifo_rdata;
            div_lat   <= baud_div;
            bit_timer <= baud_div - 16'd1;
            uart_tx   <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_done) begin
            tx_state  <= ST_DATA;
            bit_idx   <= 3'd0;
            uart_tx   <= shreg[0];
            bit_timer <= div_lat - 16'd1;
          end else begin
            bit_timer <= bit_timer - 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            bit_timer <= div_lat - 16'd1;
            if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
              tx_state <= ST_PARITY;
              uart_tx  <= ^shreg;
`else
              tx_state <= ST_STOP;
              uart_tx  <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= shreg[bit_idx + 3'd1];
            end
          end else begin
            bit_timer <= bit_timer - 16'd1;
          end
        end
`ifdef MMIO_UART_PARITY_EN
        ST_PARITY: begin
          if (bit_done) begin
            tx_state  <= ST_STOP;
            uart_tx   <= 1'b1;
            bit_timer <= div_lat - 16'd1;
          end else begin
            bit_timer <= bit_timer - 16'd1;
          end
        end
`endif
        ST_STOP: begin
          if (bit_done) begin
            if (!fifo_empty) begin
              tx_state  <= ST_START;
              shreg     <= fifo_rdata;
              div_lat   <= baud_div;
              bit_timer <= baud_div - 16'd1;
              uart_tx   <= 1'b0;
            end else begin
              tx_state <= ST_IDLE;
              uart_tx  <= 1'b1;
            end
          end else begin
            bit_timer <= bit_timer - 16'd1;
          end
        end
        default: begin
          tx_state <= ST_IDLE;
          uart_tx  <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    status = '0;
    status[ST_BUSY_BIT]  = (tx_state != ST_IDLE);
    status[ST_FULL_BIT]  = fifo_full;
    status[ST_EMPTY_BIT] = fifo_empty;
    status[ST_OVF_BIT]   = overflow;
`ifdef MMIO_UART_PARITY_EN
    status[ST_PARITY_BIT] = 1'b1;
`endif
    status[ST_COUNT_MSB:ST_COUNT_LSB] = 9'(fifo_count);
  end

  always_comb begin
    read_data = ram_read_data;
    if (mmio_hit) begin
      case (reg_off)
        OFF_STATUS:  read_data = status;
        OFF_BAUDDIV: read_data = {16'd0, baud_div};
        default:     read_data = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_bridge.sv
// Self-checking bench for mmio_uart_bridge: bus decode, register model and a
// serial-line monitor feeding a byte scoreboard.
module tb_mmio_uart_bridge;

  localparam int          FIFO_DEPTH = 8;
  localparam int          DIV_RST    = 16;
  localparam logic [31:0] BASE       = 32'hFFFF_0000;
`ifdef MMIO_UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS = 10 + PAR;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_address;
  logic [31:0] write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] read_data;
  logic [31:0] ram_read_data;
  logic        ram_write;
  logic        ram_read;
  logic        uart_tx;

  mmio_uart_bridge #(
    .FIFO_DEPTH   (FIFO_DEPTH),
    .BAUD_DIV_RST (DIV_RST),
    .MMIO_BASE    (BASE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_address  (data_address),
    .write_data    (write_data),
    .mem_write     (mem_write),
    .mem_read      (mem_read),
    .read_data     (read_data),
    .ram_read_data (ram_read_data),
    .ram_write     (ram_write),
    .ram_read      (ram_read),
    .uart_tx       (uart_tx)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rst_events = 0;
  always @(negedge rst_n) rst_events++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_start_q[$];
  int         mon_div = DIV_RST;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input bit busy, input int cnt, input bit ovf);
    logic [31:0] s;
    s = 32'd0;
    s[0] = busy;
    s[1] = (cnt == FIFO_DEPTH);
    s[2] = (cnt == 0);
    s[3] = ovf;
    s[4] = (PAR == 1);
    s[16:8] = 9'(cnt);
    return s;
  endfunction

  // Line monitor: samples each bit near its middle using the divisor the
  // bench programmed; frames hit by a reset are discarded.
  initial begin
    forever begin
      logic [7:0] b;
      logic       st_bit, par_bit, stop_bit;
      int         d, r0;
      @(negedge uart_tx);
      rx_start_q.push_back(cyc);
      d  = mon_div;
      r0 = rst_events;
      par_bit = 1'b0;
      repeat (d / 2) @(negedge clk);
      st_bit = uart_tx;
      for (int i = 0; i < 8; i++) begin
        repeat (d) @(negedge clk);
        b[i] = uart_tx;
      end
      if (PAR == 1) begin
        repeat (d) @(negedge clk);
        par_bit = uart_tx;
      end
      repeat (d) @(negedge clk);
      stop_bit = uart_tx;
      if (rst_events == r0 && rst_n === 1'b1) begin
        check("start_bit", {31'd0, st_bit}, 32'd0);
        check("stop_bit", {31'd0, stop_bit}, 32'd1);
        if (PAR == 1) check("parity_bit", {31'd0, par_bit}, {31'd0, ^b});
        rx_q.push_back(b);
      end
    end
  end

  // driver tasks
  task automatic drive_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    data_address = a;
    write_data   = d;
    mem_write    = 1'b1;
    mem_read     = 1'b0;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    mem_write = 1'b0;
    mem_read  = 1'b0;
  endtask

  task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
    drive_write(a, d);
    bus_idle();
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    mem_write    = 1'b0;
    mem_read     = 1'b1;
    data_address = a;
    #1 d = read_data;
  endtask

  task automatic drain(input string tag, input int n, input int budget);
    int waited = 0;
    while (rx_q.size() < n && waited < budget) begin
      @(posedge clk);
      waited++;
    end
    check({tag, "_frames"}, rx_q.size(), n);
    while (rx_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_byte"}, {24'd0, rx_q.pop_front()}, {24'd0, exp_q.pop_front()});
    rx_q.delete();
    exp_q.delete();
  endtask

  // stimulus
  logic [31:0] rd;
  int          k, s0, n, d;
  logic [7:0]  b;
  logic [15:0] baud_model;

  initial begin
    rst_n = 1'b0;
    data_address = 32'd0;
    write_data = 32'd0;
    mem_write = 1'b0;
    mem_read = 1'b0;
    ram_read_data = 32'd0;
    baud_model = 16'(DIV_RST);
    repeat (3) @(posedge clk);
    #1 check("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    bus_read(BASE + 32'h4, rd); check("reset_status", rd, exp_status(0, 0, 0));
    bus_read(BASE + 32'h8, rd); check("reset_bauddiv", rd, 32'(DIV_RST));
    bus_read(BASE + 32'h0, rd); check("txdata_reads_zero", rd, 32'd0);
    bus_read(BASE + 32'hC, rd); check("reserved_reads_zero", rd, 32'd0);
    check("idle_uart_tx", {31'd0, uart_tx}, 32'd1);

    write_reg(BASE + 32'h8, 32'd0);
    bus_read(BASE + 32'h8, rd); check("bauddiv_zero_as_one", rd, 32'd1);
    write_reg(BASE + 32'hC, 32'hFFFF_FFFF);
    bus_read(BASE + 32'hC, rd); check("reserved_write_ignored", rd, 32'd0);
    write_reg(BASE + 32'h8, 32'h1234_0004);
    bus_read(BASE + 32'h8, rd); check("bauddiv_16bit", rd, 32'd4);

    // single frame, divisor 4: start bit one cycle after the push edge
    mon_div = 4;
    drive_write(BASE, 32'h0000_00A5);
    exp_q.push_back(8'hA5);
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    data_address = BASE + 32'h4;
    check("tx_high_at_push_edge", {31'd0, uart_tx}, 32'd1);
    @(posedge clk);
    #1 check("tx_start_low", {31'd0, uart_tx}, 32'd0);
    k = 0;
    while (read_data[0] && k < 200) begin
      @(posedge clk);
      #1 k++;
    end
    check("frame_busy_cycles", k, 4 * NBITS);
    drain("a5", 1, 100);

    // burst: one byte pops at once, FIFO_DEPTH more fill the FIFO, so the
    // (FIFO_DEPTH+2)-th write is the first one dropped
    write_reg(BASE + 32'h8, 32'd16);
    baud_model = 16'd16;
    mon_div = 16;
    s0 = rx_start_q.size();
    for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
      b = 8'($urandom);
      drive_write(BASE, {24'd0, b});
      if (i < FIFO_DEPTH + 1) exp_q.push_back(b);
    end
    bus_idle();
    bus_read(BASE + 32'h4, rd); check("burst_status_ovf", rd, exp_status(1, FIFO_DEPTH, 1));
    write_reg(BASE + 32'h4, 32'h0000_0008);
    bus_read(BASE + 32'h4, rd); check("burst_status_clr", rd, exp_status(1, FIFO_DEPTH, 0));
    drain("burst", FIFO_DEPTH + 1, (FIFO_DEPTH + 1) * NBITS * 16 + 200);
    for (int i = 1; i <= FIFO_DEPTH; i++)
      if (rx_start_q.size() > s0 + i)
        check("burst_gap", rx_start_q[s0 + i] - rx_start_q[s0 + i - 1], NBITS * 16);
    check("burst_start_count", rx_start_q.size() - s0, FIFO_DEPTH + 1);
    repeat (20) @(posedge clk);
    bus_read(BASE + 32'h4, rd); check("burst_status_idle", rd, exp_status(0, 0, 0));

    // parity patterns (also plain frames in the 8N1 build)
    drive_write(BASE, 32'h07); exp_q.push_back(8'h07);
    drive_write(BASE, 32'h03); exp_q.push_back(8'h03);
    bus_idle();
    drain("parity", 2, 2 * NBITS * 16 + 200);
    repeat (20) @(posedge clk);

    // randomized frames with random divisors and gaps
    for (int r = 0; r < 4; r++) begin
      d = $urandom_range(2, 12);
      write_reg(BASE + 32'h8, d);
      baud_model = 16'(d);
      mon_div = d;
      n = $urandom_range(1, FIFO_DEPTH);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        drive_write(BASE, {24'd0, b});
        exp_q.push_back(b);
        if ($urandom_range(0, 1) == 1) bus_idle();
      end
      bus_idle();
      drain("rand", n, n * NBITS * d + 200);
      repeat (d + 4) @(posedge clk);
    end

    // directed RAM path
    @(negedge clk);
    data_address = 32'h0000_0100; write_data = 32'hDEAD_BEEF;
    mem_write = 1'b1; mem_read = 1'b0; ram_read_data = 32'h1357_9BDF;
    #1 check("ram_store_strobe", {31'd0, ram_write}, 32'd1);
    @(negedge clk);
    mem_write = 1'b0; mem_read = 1'b1;
    #1 check("ram_load_strobe", {31'd0, ram_read}, 32'd1);
    check("ram_load_data", read_data, 32'h1357_9BDF);
    @(negedge clk);
    data_address = BASE; write_data = 32'h5A; mem_write = 1'b1; mem_read = 1'b0;
    #1 check("mmio_store_no_ram", {31'd0, ram_write}, 32'd0);
    exp_q.push_back(8'h5A);
    bus_idle();
    drain("mmio_store", 1, NBITS * mon_div + 100);
    repeat (mon_div + 4) @(posedge clk);

    // randomized decode: RAM accesses anywhere, MMIO reads only
    for (int i = 0; i < 24; i++) begin
      logic        hit;
      logic [31:0] exp_rd;
      @(negedge clk);
      ram_read_data = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        data_address = BASE | 32'($urandom_range(0, 15));
        mem_write = 1'b0;
        mem_read = 1'($urandom_range(0, 1));
      end else begin
        data_address = $urandom;
        if (data_address[31:4] == BASE[31:4]) data_address[31] = ~data_address[31];
        mem_write = 1'($urandom_range(0, 1));
        mem_read = 1'($urandom_range(0, 1));
      end
      hit = (data_address[31:4] == BASE[31:4]);
      if (!hit) exp_rd = ram_read_data;
      else case (data_address[3:2])
        2'd1:    exp_rd = exp_status(0, 0, 0);
        2'd2:    exp_rd = {16'd0, baud_model};
        default: exp_rd = 32'd0;
      endcase
      #1;
      check("rand_ram_write", {31'd0, ram_write}, {31'd0, mem_write & ~hit});
      check("rand_ram_read", {31'd0, ram_read}, {31'd0, mem_read & ~hit});
      check("rand_read_data", read_data, exp_rd);
    end
    bus_idle();

    // reset mid-frame
    write_reg(BASE + 32'h8, 32'd8);
    mon_div = 8;
    drive_write(BASE, 32'h3C);
    drive_write(BASE, 32'hC3);
    drive_write(BASE, 32'h99);
    bus_idle();
    repeat (30) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_uart_tx_high", {31'd0, uart_tx}, 32'd1);
    data_address = BASE + 32'h4;
    #1 check("rst_status", read_data, exp_status(0, 0, 0));
    data_address = BASE + 32'h8;
    #1 check("rst_bauddiv", read_data, 32'(DIV_RST));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    s0 = rx_start_q.size();
    repeat (300) @(posedge clk);
    check("no_residual_frame", rx_start_q.size() - s0, 0);
    check("aborted_frame_dropped", rx_q.size(), 0);
    bus_read(BASE + 32'h4, rd); check("post_rst_status", rd, exp_status(0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
